// File: rtl/uart_rx_parity.sv
// ---------------------------------------------------------------------------
// uart_rx_parity
//   UART receiver with 16x oversampling and an optional parity check.
//   It receives frames made of a start bit (0), DBIT data bits sent LSB
//   first, an optional parity bit and a stop bit (1) held for SB_TICK ticks.
//   Each bit is sampled in the middle of its bit period. The received byte
//   and its error flags are registered together. The one-cycle
//   rx_done_tick pulse rises in the same cycle as the new values.
//
// Ports
//   clk           in   1     system clock, rising edge
//   reset         in   1     synchronous, active-high
//   rx            in   1     serial input, idle high, asynchronous to clk
//   s_tick        in   1     one-clk oversample strobe, 16 per bit period
//   dout          out  DBIT  last received data word
//   rx_done_tick  out  1     one-clk pulse when a frame completes
//   parity_err    out  1     parity mismatch of last frame
//   frame_err     out  1     stop bit of last frame sampled low
// ---------------------------------------------------------------------------
module uart_rx_parity #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err
);

  // Tick counter must also span the stop-bit duration (up to 2 stop bits).
  localparam int unsigned S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int unsigned N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [S_W-1:0] S_MID  = S_W'(7);
  localparam logic [S_W-1:0] S_LAST = S_W'(15);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);
  localparam logic           PAR_EN_BIT  = (PARITY_EN != 0);
  localparam logic           PAR_ODD_BIT = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic            r_rx_meta;
  logic            r_rx_s;
  logic [S_W-1:0]  r_s;
  logic [N_W-1:0]  r_n;
  logic [DBIT-1:0] r_b;
  logic            r_p;

  logic [S_W-1:0]  w_s_next;
  logic [N_W-1:0]  w_n_next;
  logic [DBIT-1:0] w_b_next;
  logic            w_p_next;
  logic [DBIT-1:0] w_dout_next;
  logic            w_done_next;
  logic            w_perr_next;
  logic            w_ferr_next;
  logic            w_par_bad;

  // Two-flop synchronizer; resets high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        // If the line is high again at mid start bit, the edge was a glitch.
        if (s_tick && (r_s == S_MID)) begin
          w_state_next = r_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (s_tick && (r_s == S_LAST) && (r_n == N_LAST)) begin
          w_state_next = PAR_EN_BIT ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (s_tick && (r_s == S_LAST)) begin
          w_state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (s_tick && (r_s == S_STOP)) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Data bits XORed with the parity bit must equal the configured parity sense.
  assign w_par_bad = PAR_EN_BIT & (((^r_b) ^ r_p) != PAR_ODD_BIT);

  // Datapath and output next values.
  always_comb begin
    w_s_next    = r_s;
    w_n_next    = r_n;
    w_b_next    = r_b;
    w_p_next    = r_p;
    w_dout_next = dout;
    w_done_next = 1'b0;
    w_perr_next = parity_err;
    w_ferr_next = frame_err;
    case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_s_next = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (r_s == S_MID) begin
            w_s_next = '0;
            w_n_next = '0;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (r_s == S_LAST) begin
            w_s_next = '0;
            // LSB arrives first, so shift new bits in from the top.
            w_b_next = DBIT'({r_rx_s, r_b} >> 1);
            if (r_n != N_LAST) begin
              w_n_next = r_n + 1'b1;
            end
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (r_s == S_LAST) begin
            w_s_next = '0;
            w_p_next = r_rx_s;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (r_s == S_STOP) begin
            w_s_next    = '0;
            w_dout_next = r_b;
            w_done_next = 1'b1;
            w_perr_next = w_par_bad;
            w_ferr_next = ~r_rx_s;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      default: begin
        w_s_next = '0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s          <= '0;
      r_n          <= '0;
      r_b          <= '0;
      r_p          <= 1'b0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      r_s          <= w_s_next;
      r_n          <= w_n_next;
      r_b          <= w_b_next;
      r_p          <= w_p_next;
      dout         <= w_dout_next;
      rx_done_tick <= w_done_next;
      parity_err   <= w_perr_next;
      frame_err    <= w_ferr_next;
    end
  end

endmodule

// File: tb/tb_uart_rx_parity.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_parity
//   Self-checking bench for uart_rx_parity (8 data bits, even parity, one
//   stop bit). A serial model drives rx, and expected frames are queued when
//   they are sent. A monitor captures every rx_done_tick into an observed
//   queue, and each test compares the two queues.
// ---------------------------------------------------------------------------
module tb_uart_rx_parity;

  localparam int unsigned DBIT = 8;

  logic            clk;
  logic            reset;
  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            parity_err;
  logic            frame_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [1:0] tick_div = 2'd0;

  // {dout, parity_err, frame_err}
  logic [DBIT+1:0] exp_q[$];
  logic [DBIT+1:0] obs_q[$];

  uart_rx_parity #(
    .DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One s_tick every 4 clocks -> 64 clocks per bit.
  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      s_tick = (tick_div == 2'd3);
      tick_div = tick_div + 2'd1;
    end
  end

  // Capture every completed frame.
  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      obs_q.push_back({dout, parity_err, frame_err});
      done_cnt = done_cnt + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic v, input int nt);
    @(negedge clk);
    rx = v;
    repeat (nt) begin
      do @(posedge clk); while (s_tick !== 1'b1);
    end
  endtask

  // A low stop bit is held only 10 ticks so the receiver's restart sees high.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop_b);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
    send_bit(p, 16);
    if (stop_b) begin
      send_bit(1'b1, 16);
    end else begin
      send_bit(1'b0, 10);
      send_bit(1'b1, 6);
    end
  endtask

  function automatic logic [DBIT+1:0] model(input logic [7:0] d, input logic p,
                                             input logic stop_b);
    logic perr;
    perr = ((^d) ^ p) != 1'b0;
    return {d, perr, ~stop_b};
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_dout: got %h expected 00", dout);
    end
    checks++;
    if (rx_done_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", rx_done_tick);
    end
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_perr: got %b expected 0", parity_err);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ferr: got %b expected 0", frame_err);
    end
    reset = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_single(input string name, input logic [7:0] d,
                             input logic p, input logic stop_b);
    logic [DBIT+1:0] e;
    logic [DBIT+1:0] o;
    int d0;
    d0 = done_cnt;
    exp_q.push_back(model(d, p, stop_b));
    send_frame(d, p, stop_b);
    for (int k = 0; k < 400 && obs_q.size() < 1; k++) @(negedge clk);
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d expected 1", name, done_cnt - d0);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o[DBIT+1:2] !== e[DBIT+1:2]) begin
        errors++;
        $display("FAIL %s_dout: got %h expected %h", name, o[DBIT+1:2], e[DBIT+1:2]);
      end
      checks++;
      if (o[1] !== e[1]) begin
        errors++;
        $display("FAIL %s_parity_err: got %b expected %b", name, o[1], e[1]);
      end
      checks++;
      if (o[0] !== e[0]) begin
        errors++;
        $display("FAIL %s_frame_err: got %b expected %b", name, o[0], e[0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_good_parity;
    test_single("good", 8'hB5, 1'b1, 1'b1);
  endtask

  task automatic test_parity_err;
    test_single("parity", 8'hB5, 1'b0, 1'b1);
  endtask

  task automatic test_frame_err;
    test_single("framing", 8'hE7, 1'b0, 1'b0);
  endtask

  task automatic test_glitch;
    logic [7:0] dout_before;
    int d0;
    dout_before = 8'hE7;
    d0 = done_cnt;
    send_bit(1'b0, 4);
    send_bit(1'b1, 40);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL glitch_done_count: got %0d expected 0", done_cnt - d0);
    end
    checks++;
    if (dout !== dout_before) begin
      errors++;
      $display("FAIL glitch_dout: got %h expected %h", dout, dout_before);
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    int d0;
    d = 8'hE3;
    d0 = done_cnt;
    send_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) send_bit(d[i], 16);
    send_bit(d[3], 8);
    @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL midreset_dout: got %h expected 00", dout);
    end
    checks++;
    if (frame_err !== 1'b0 || parity_err !== 1'b0 || rx_done_tick !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags: got p=%b f=%b d=%b expected 0 0 0",
               parity_err, frame_err, rx_done_tick);
    end
    send_bit(1'b1, 32);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL midreset_no_done: got %0d expected 0", done_cnt - d0);
    end
    obs_q.delete();
    test_single("after_reset", 8'hE3, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic [DBIT+1:0] e;
    logic [DBIT+1:0] o;
    int d0;
    d0 = done_cnt;
    exp_q.push_back(model(8'hE7, 1'b0, 1'b1));
    exp_q.push_back(model(8'hE3, 1'b1, 1'b1));
    send_frame(8'hE7, 1'b0, 1'b1);
    send_frame(8'hE3, 1'b1, 1'b1);
    for (int k = 0; k < 400 && obs_q.size() < 2; k++) @(negedge clk);
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b_frame: got dout=%h p=%b f=%b expected dout=%h p=%b f=%b",
                 o[DBIT+1:2], o[1], o[0], e[DBIT+1:2], e[1], e[0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    rx = 1'b1;
    reset = 1'b1;
    test_reset();
    test_good_parity();
    test_parity_err();
    test_frame_err();
    test_glitch();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
